// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the two-requester memory
//               arbiter: FSM state encoding, request-source encoding,
//               I/O window sizing and the I/O-window address decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Transaction sequencer states: arbitrate, drive the access, acknowledge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Which requester owns the current transaction.
    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } src_t;

    localparam int          DEFAULT_PORT_EXPONENT = 3;
    localparam int unsigned PORT_COUNT            = 2 ** DEFAULT_PORT_EXPONENT;
    localparam int unsigned IO_LIMIT              = 2 * PORT_COUNT;

    // An address belongs to the I/O window when it lies below the limit.
    // The limit is passed in so a top built with a non-default exponent
    // decodes its own window.
    function automatic logic is_io(input logic [15:0] addr,
                                   input int unsigned limit = IO_LIMIT);
        return ({16'd0, addr} < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Purely combinational grant selection between the fetch and
//               data requesters.
//               Build option MEM_ARB_RR_EN:
//                 defined   - round-robin; on contention the requester that
//                             was not granted last wins.
//                 undefined - fixed priority; data always beats fetch and
//                             the last-grant input is ignored.
// Ports       : i_f_req  - fetch request
//               i_d_req  - data request
//               i_last   - source granted most recently
//               o_valid  - at least one request present
//               o_grant  - selected source (meaningful when o_valid = 1)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic i_f_req,
    input  logic i_d_req,
    input  src_t i_last,
    output logic o_valid,
    output src_t o_grant
);

    assign o_valid = i_f_req | i_d_req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        o_grant = SRC_DATA;
        if (i_f_req && i_d_req) begin
            // Contention: hand the port to whoever did not have it last.
            o_grant = (i_last == SRC_DATA) ? SRC_FETCH : SRC_DATA;
        end else if (i_f_req) begin
            o_grant = SRC_FETCH;
        end
    end
`else
    // The last-grant history has no influence under fixed priority.
    logic w_unused_last;
    assign w_unused_last = i_last;

    assign o_grant = i_d_req ? SRC_DATA : SRC_FETCH;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester memory arbiter in front of the 16-bit data RAM.
//               Serialises instruction fetches and load/store accesses onto
//               the single RAM port and steers addresses inside the I/O
//               window (0 .. 2*2^PORT_EXPONENT-1) to the I/O bus instead.
//               Every transaction is IDLE (arbitrate) -> ACCESS -> ACK.
//               Build option MEM_ARB_RR_EN selects round-robin arbitration
//               (see mem_arb_pick); otherwise data has fixed priority.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               i_f_req/i_f_addr           - fetch request (held until ack)
//               o_f_ack/o_f_rdata          - fetch ack pulse / read data
//               i_d_req/i_d_we/i_d_addr/
//               i_d_wdata                  - data request (held until ack)
//               o_d_ack/o_d_rdata          - data ack pulse / read data
//               o_ram_read/o_ram_write/
//               o_ram_addr/o_ram_d_in      - RAM port (write commits on negedge)
//               i_ram_d_out                - RAM read data (combinational)
//               o_io_read/o_io_write/
//               o_io_addr/o_io_wdata       - I/O port bus
//               i_io_rdata                 - I/O read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int PORT_EXPONENT = DEFAULT_PORT_EXPONENT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_f_req,
    input  logic [15:0] i_f_addr,
    output logic        o_f_ack,
    output logic [15:0] o_f_rdata,

    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [15:0] i_d_addr,
    input  logic [15:0] i_d_wdata,
    output logic        o_d_ack,
    output logic [15:0] o_d_rdata,

    output logic        o_ram_read,
    output logic        o_ram_write,
    output logic [15:0] o_ram_addr,
    output logic [15:0] o_ram_d_in,
    input  logic [15:0] i_ram_d_out,

    output logic        o_io_read,
    output logic        o_io_write,
    output logic [15:0] o_io_addr,
    output logic [15:0] o_io_wdata,
    input  logic [15:0] i_io_rdata
);

    localparam int unsigned c_IO_LIMIT = 2 * (2 ** PORT_EXPONENT);

    // Sequencer and transaction registers
    state_t      r_state;
    src_t        r_src;
    src_t        r_last;
    logic        r_io;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;

    // Registered outputs
    logic        r_ram_read;
    logic        r_ram_write;
    logic        r_io_read;
    logic        r_io_write;
    logic        r_f_ack;
    logic        r_d_ack;
    logic [15:0] r_f_rdata;
    logic [15:0] r_d_rdata;

    // Winner selection and its request fields
    logic        w_valid;
    src_t        w_grant;
    logic [15:0] w_win_addr;
    logic [15:0] w_win_wdata;
    logic        w_win_we;
    logic        w_win_io;
    logic [15:0] w_rdata;

    mem_arb_pick u_pick (
        .i_f_req (i_f_req),
        .i_d_req (i_d_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    // Fetches are always reads; their write-enable and write data are forced
    // to zero so a stale d_we can never turn a fetch into a write.
    assign w_win_addr  = (w_grant == SRC_DATA) ? i_d_addr  : i_f_addr;
    assign w_win_wdata = (w_grant == SRC_DATA) ? i_d_wdata : 16'h0000;
    assign w_win_we    = (w_grant == SRC_DATA) & i_d_we;
    assign w_win_io    = is_io(w_win_addr, c_IO_LIMIT);

    assign w_rdata     = r_io ? i_io_rdata : i_ram_d_out;

    // Strobes are loaded in IDLE so they are high exactly for the ACCESS
    // cycle and come straight from flops (glitch-free). The async reset
    // drops them immediately, which aborts a write before the RAM's negedge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src       <= SRC_FETCH;
            r_last      <= SRC_FETCH;
            r_io        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_io_read   <= 1'b0;
            r_io_write  <= 1'b0;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_f_rdata   <= 16'h0000;
            r_d_rdata   <= 16'h0000;
        end else begin
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_io_read   <= 1'b0;
            r_io_write  <= 1'b0;
            r_f_ack     <= 1'b0;
            r_d_ack     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_src       <= w_grant;
                        r_last      <= w_grant;
                        r_io        <= w_win_io;
                        r_we        <= w_win_we;
                        r_addr      <= w_win_addr;
                        r_wdata     <= w_win_wdata;
                        r_ram_read  <= ~w_win_io & ~w_win_we;
                        r_ram_write <= ~w_win_io &  w_win_we;
                        r_io_read   <=  w_win_io & ~w_win_we;
                        r_io_write  <=  w_win_io &  w_win_we;
                        r_state     <= ACCESS;
                    end
                end

                ACCESS: begin
                    // Only the winner's read register changes; writes leave
                    // both read registers untouched.
                    if (!r_we) begin
                        if (r_src == SRC_FETCH) begin
                            r_f_rdata <= w_rdata;
                        end else begin
                            r_d_rdata <= w_rdata;
                        end
                    end
                    r_f_ack <= (r_src == SRC_FETCH);
                    r_d_ack <= (r_src == SRC_DATA);
                    r_state <= ACK;
                end

                ACK: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_f_ack     = r_f_ack;
    assign o_f_rdata   = r_f_rdata;
    assign o_d_ack     = r_d_ack;
    assign o_d_rdata   = r_d_rdata;
    assign o_ram_read  = r_ram_read;
    assign o_ram_write = r_ram_write;
    assign o_ram_addr  = r_addr;
    assign o_ram_d_in  = r_wdata;
    assign o_io_read   = r_io_read;
    assign o_io_write  = r_io_write;
    assign o_io_addr   = r_addr;
    assign o_io_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A RAM and an I/O
//               register file surround the DUT; a transaction-level model
//               predicts every output on every cycle from the grant time of
//               each transaction. Directed tests pin the model with literal
//               values, then two random requesters run concurrently.
//               Honours MEM_ARB_RR_EN for the expected arbitration order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int unsigned IO_LIM = 16;   // 2 * 2^3

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0;
    logic [15:0] d_wdata = 16'h0;
    logic        f_ack, d_ack, ram_read, ram_write, io_read, io_write;
    logic [15:0] f_rdata, d_rdata, ram_addr, ram_d_in, ram_d_out;
    logic [15:0] io_addr, io_wdata, io_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.PORT_EXPONENT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack), .o_f_rdata(f_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(d_ack), .o_d_rdata(d_rdata),
        .o_ram_read(ram_read), .o_ram_write(ram_write), .o_ram_addr(ram_addr),
        .o_ram_d_in(ram_d_in), .i_ram_d_out(ram_d_out),
        .o_io_read(io_read), .o_io_write(io_write), .o_io_addr(io_addr),
        .o_io_wdata(io_wdata), .i_io_rdata(io_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- environment: RAM and I/O registers ----------------
    function automatic logic [15:0] ram_init(input int a);
        if (a == 32'h0100) return 16'hBEEF;
        if (a == 32'h4000) return 16'h7777;
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] io_init(input int i);
        return 16'hC000 | 16'(i * 257);
    endfunction

    logic [15:0] ram [0:65535];
    logic [15:0] iox [0:15];

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= ram_init(i);
        for (int i = 0; i < 16; i++) iox[i] <= io_init(i);
    end

    assign ram_d_out = ram[ram_addr];
    assign io_rdata  = iox[io_addr[3:0]];

    always @(negedge clk) begin
        if (ram_write) ram[ram_addr] <= ram_d_in;
        if (io_write)  iox[io_addr[3:0]] <= io_wdata;
    end

    // ---------------- transaction-level reference model ----------------
    logic [15:0] model_ram [int];
    logic [15:0] model_io [0:15];
    int          cyc = 0;
    int          g = -10;          // posedge number at which the live txn was granted
    int          next_sample = 0;  // first posedge at which a new grant may happen
    bit          tv = 0, t_src = 0, t_we = 0, t_io = 0, last_d = 0;
    logic [15:0] t_addr = 0, t_wdata = 0;
    logic [15:0] exp_frd = 0, exp_drd = 0, exp_addr = 0, exp_wdata = 0;

    initial for (int i = 0; i < 16; i++) model_io[i] = io_init(i);

    function automatic logic [15:0] mread(input logic [15:0] a);
        if (model_ram.exists(int'(a))) return model_ram[int'(a)];
        return ram_init(int'(a));
    endfunction

    task automatic model_reset();
        tv = 0; next_sample = 0; last_d = 0;
        exp_frd = 0; exp_drd = 0; exp_addr = 0; exp_wdata = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic [15:0] v;
            bit pick_d;
            cyc++;
            // Read data lands in the winner's register one cycle after grant.
            if (tv && cyc == g + 1 && !t_we) begin
                v = t_io ? model_io[t_addr[3:0]] : mread(t_addr);
                if (t_src) exp_drd = v; else exp_frd = v;
            end
            if (cyc >= next_sample && (f_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
                if (f_req && d_req) pick_d = !last_d;
                else                pick_d = d_req;
`else
                pick_d = d_req;
`endif
                t_src   = pick_d;
                t_addr  = pick_d ? d_addr : f_addr;
                t_we    = pick_d & d_we;
                t_wdata = pick_d ? d_wdata : 16'h0;
                t_io    = ({16'd0, t_addr} < IO_LIM);
                tv = 1; g = cyc; next_sample = cyc + 3; last_d = pick_d;
                exp_addr = t_addr; exp_wdata = t_wdata;
            end
        end
    end

    // Per-cycle comparison; also commits model writes at the RAM's negedge.
    always @(negedge clk) begin
        bit acc, ackc;
        acc  = tv && rst_n && (cyc == g);
        ackc = tv && rst_n && (cyc == g + 1);
        chk("cyc_strobes_acks", {ram_read, ram_write, io_read, io_write, f_ack, d_ack},
            {acc && !t_io && !t_we, acc && !t_io && t_we, acc && t_io && !t_we,
             acc && t_io && t_we, ackc && !t_src, ackc && t_src});
        chk("cyc_f_rdata", f_rdata, exp_frd);
        chk("cyc_d_rdata", d_rdata, exp_drd);
        chk("cyc_ram_addr", ram_addr, exp_addr);
        chk("cyc_io_addr", io_addr, exp_addr);
        chk("cyc_ram_d_in", ram_d_in, exp_wdata);
        chk("cyc_io_wdata", io_wdata, exp_wdata);
        if (acc && t_we) begin
            if (t_io) model_io[t_addr[3:0]] = t_wdata;
            else      model_ram[int'(t_addr)] = t_wdata;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic txn(input bit is_d, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, output int lat,
                       output int c_rr, output int c_rw, output int c_ir, output int c_iw);
        bit done;
        @(posedge clk); #2;
        if (is_d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else      begin f_req = 1; f_addr = a; end
        lat = 0; c_rr = 0; c_rw = 0; c_ir = 0; c_iw = 0; done = 0;
        while (!done && lat < 20) begin
            @(negedge clk); #1;
            lat++;
            c_rr += int'(ram_read); c_rw += int'(ram_write);
            c_ir += int'(io_read);  c_iw += int'(io_write);
            done = is_d ? d_ack : f_ack;
        end
        chk("txn_ack_seen", 32'(done), 1);
        @(posedge clk); #2;
        if (is_d) d_req = 0; else f_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0; f_req = 0; d_req = 0;
        @(posedge clk); #2;
        rst_n = 1;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 16'($urandom_range(0, IO_LIM - 1));
            1: return 16'(IO_LIM - 1);
            2: return 16'(IO_LIM);
            3: return 16'hFFFF;
            4: return 16'h0100 + 16'($urandom_range(0, 3));
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic fetch_drv(input int n);
        for (int k = 0; k < n; k++) begin
            int dly, cnt;
            bit got;
            dly = $urandom_range(0, 3);
            repeat (dly) begin @(posedge clk); #2; end
            f_req = 1; f_addr = rand_addr();
            cnt = 0; got = 0;
            while (!got && cnt < 40) begin @(negedge clk); cnt++; got = f_ack; end
            chk("rand_fetch_acked", 32'(got), 1);
            @(posedge clk); #2;
            f_req = 0;
        end
    endtask

    task automatic data_drv(input int n);
        for (int k = 0; k < n; k++) begin
            int dly, cnt;
            bit got;
            // At least one idle cycle so fixed priority cannot starve fetch.
            dly = $urandom_range(1, 3);
            repeat (dly) begin @(posedge clk); #2; end
            d_req = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1));
            d_wdata = 16'($urandom_range(0, 65535));
            cnt = 0; got = 0;
            while (!got && cnt < 40) begin @(negedge clk); cnt++; got = d_ack; end
            chk("rand_data_acked", 32'(got), 1);
            @(posedge clk); #2;
            d_req = 0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, rr, rw, ir, iw, nack, t_first, t_last, idx, nrd;
        logic [3:0]  seq;
        logic [15:0] rd_addr [2];

        #1 rst_n = 0;
        @(negedge clk);
        chk("reset_ctrl", {ram_read, ram_write, io_read, io_write, f_ack, d_ack}, 0);
        chk("reset_data", {f_rdata | d_rdata | ram_addr | ram_d_in | io_addr | io_wdata}, 0);
        @(posedge clk); #2 rst_n = 1;

        // Fetch read of preset RAM word: ack on 3rd negedge after request.
        txn(0, 0, 16'h0100, 16'h0, lat, rr, rw, ir, iw);
        chk("fetch_latency", lat, 3);
        chk("fetch_ram_read_cycles", rr, 1);
        chk("fetch_other_strobes", rw + ir + iw, 0);
        chk("fetch_rdata", f_rdata, 16'hBEEF);

        // Data write then read back.
        txn(1, 1, 16'h8000, 16'h1234, lat, rr, rw, ir, iw);
        chk("dwr_latency", lat, 3);
        chk("dwr_ram_write_cycles", rw, 1);
        txn(1, 0, 16'h8000, 16'h0, lat, rr, rw, ir, iw);
        chk("drd_latency", lat, 3);
        chk("drd_rdata", d_rdata, 16'h1234);

        // I/O window: last I/O address, then first RAM address above it.
        txn(1, 1, 16'h000F, 16'h00AA, lat, rr, rw, ir, iw);
        chk("io_write_cycles", iw, 1);
        chk("io_ram_write_cycles", rw, 0);
        chk("io_wdata_held", io_wdata, 16'h00AA);
        txn(1, 0, 16'h000F, 16'h0, lat, rr, rw, ir, iw);
        chk("io_read_cycles", ir, 1);
        chk("io_read_data", d_rdata, 16'h00AA);
        txn(1, 0, 16'h0010, 16'h0, lat, rr, rw, ir, iw);
        chk("addr10_ram_read", rr, 1);
        chk("addr10_io_read", ir, 0);
        chk("addr10_rdata", d_rdata, 16'hB92A);
        txn(0, 0, 16'hFFFF, 16'h0, lat, rr, rw, ir, iw);
        chk("addrffff_ram_read", rr, 1);
        chk("addrffff_rdata", f_rdata, 16'h3B93);

        // Held request with address changed during ACK.
        @(posedge clk); #2;
        d_req = 1; d_we = 0; d_addr = 16'h0200;
        nack = 0; nrd = 0; idx = 0; t_first = 0; t_last = 0;
        rd_addr[0] = 16'hDEAD; rd_addr[1] = 16'hDEAD;
        while (nack < 2 && idx < 30) begin
            @(negedge clk); #1;
            idx++;
            if (ram_read) begin
                if (nrd < 2) rd_addr[nrd] = ram_addr;
                nrd++;
            end
            if (d_ack) begin
                nack++;
                if (nack == 1) begin t_first = idx; d_addr = 16'h0300; end
                else t_last = idx;
            end
        end
        @(posedge clk); #2 d_req = 0;
        chk("held_ack_count", nack, 2);
        chk("held_read_count", nrd, 2);
        chk("held_addr0", rd_addr[0], 16'h0200);
        chk("held_addr1", rd_addr[1], 16'h0300);
        chk("held_ack_spacing", t_last - t_first, 3);

        // Contention from reset: both requests held for four grants.
        do_reset();
        @(posedge clk); #2;
        f_req = 1; f_addr = 16'h0100; d_req = 1; d_we = 0; d_addr = 16'h0400;
        nack = 0; idx = 0; seq = 4'h0; t_first = 0; t_last = 0;
        while (nack < 4 && idx < 40) begin
            @(negedge clk); #1;
            idx++;
            if (f_ack || d_ack) begin
                seq = {seq[2:0], d_ack};
                nack++;
                if (nack == 1) t_first = idx;
                if (nack == 4) t_last = idx;
            end
        end
        @(posedge clk); #2 f_req = 0; d_req = 0;
        chk("cont_ack_count", nack, 4);
`ifdef MEM_ARB_RR_EN
        chk("cont_order_DFDF", seq, 4'b1010);
`else
        chk("cont_order_DDDD", seq, 4'b1111);
`endif
        chk("cont_throughput", t_last - t_first, 9);

        // Reset during a write ACCESS, before the RAM negedge.
        @(posedge clk); #2;
        d_req = 1; d_we = 1; d_addr = 16'h4000; d_wdata = 16'h1111;
        @(posedge clk); #2;
        rst_n = 0; d_req = 0;
        @(negedge clk); #1;
        chk("abort_ctrl_zero", {ram_read, ram_write, io_read, io_write, f_ack, d_ack}, 0);
        chk("abort_data_zero", {f_rdata | d_rdata | ram_addr | ram_d_in | io_addr | io_wdata}, 0);
        @(posedge clk); #2 rst_n = 1;
        nack = 0;
        repeat (4) begin @(negedge clk); #1; nack += int'(d_ack); end
        chk("abort_no_ack", nack, 0);
        chk("abort_ram_unchanged", ram[16'h4000], 16'h7777);
        txn(1, 0, 16'h4000, 16'h0, lat, rr, rw, ir, iw);
        chk("abort_readback", d_rdata, 16'h7777);

        // Randomised concurrent traffic against the model.
        fork
            fetch_drv(40);
            data_drv(40);
        join
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
